f_norm_arbiter: RTL and testbench

//  Shares the single f_normal back-end among the FP adder (src 0), multiplier (src 1) and divider (src 2).
//  - Buffers one request per source and arbitrates round-robin.
//  - Drives f_normal inputs and its a_wait/flush, tagging each op through info as {tag, src[1:0], valid}.
//  - Steers normalized results back to the owning unit.
//  - Tracks in-flight ops for drain/idle detection.

---
 rtl/f_norm_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_f_norm_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/f_norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : f_norm_arbiter
// Brief    : Shares one f_normal back-end among the FP adder (src 0), the
//            multiplier (src 1) and the divider (src 2). Each source has a
//            one-entry buffer. Buffered ops are arbitrated round-robin and
//            tagged through info as {tag, src, valid}. Normalized results
//            are steered back by their src field. The block also counts
//            in-flight ops so drain and idle can be detected.
// Config   : F_NORM_ARB_DIV_PRIO_EN - when defined, the divider slot has
//            absolute priority. Round-robin then runs only between src 0
//            and src 1.
// Revision : 1.0 - initial release
// ============================================================================
module f_norm_arbiter #(
  parameter  int TAG_W  = 5,
  localparam int INFO_W = TAG_W + 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [3*13-1:0]     req_exp,
  input  logic [3*108-1:0]    req_frac,
  input  logic [2:0]          req_signed,
  input  logic [2:0]          req_sign,
  input  logic [2:0]          req_invalid,
  input  logic [3*TAG_W-1:0]  req_tag,
  output logic                nm_wait,
  output logic                nm_flush,
  output logic [12:0]         nm_exp,
  output logic [107:0]        nm_frac,
  output logic                nm_signed,
  output logic                nm_sign,
  output logic                nm_invalid,
  output logic [INFO_W-1:0]   nm_info,
  input  logic [INFO_W-1:0]   nm_info_out,
  output logic                res_valid,
  output logic [1:0]          res_src,
  output logic [TAG_W-1:0]    res_tag,
  input  logic                res_ready,
  output logic [1:0]          inflight,
  output logic                idle
);

  localparam int c_NSRC   = 3;
  localparam int c_EXP_W  = 13;
  localparam int c_FRAC_W = 108;

  // Per-source request slots
  logic [c_NSRC-1:0]   r_slot_full;
  logic [c_EXP_W-1:0]  r_exp    [c_NSRC];
  logic [c_FRAC_W-1:0] r_frac   [c_NSRC];
  logic [c_NSRC-1:0]   r_signed;
  logic [c_NSRC-1:0]   r_sign;
  logic [c_NSRC-1:0]   r_invalid;
  logic [TAG_W-1:0]    r_tag    [c_NSRC];

  logic [1:0]          r_rr;
  logic [1:0]          r_inflight;

  logic [2:0]          w_pick;       // {hit, index}
  logic [2:0]          w_grant;
  logic                w_grant_any;
  logic [1:0]          w_grant_src;
  logic [1:0]          w_rr_next;
  logic [2:0]          w_accept;
  logic                w_consume;

  // Find the first full slot, searching in the order p0, p1, p2.
  function automatic logic [2:0] f_pick(input logic [2:0] full,
                                        input logic [1:0] p0,
                                        input logic [1:0] p1,
                                        input logic [1:0] p2);
    if (full[p0]) return {1'b1, p0};
    if (full[p1]) return {1'b1, p1};
    if (full[p2]) return {1'b1, p2};
    return 3'b000;
  endfunction

  // The result side is gated by flush, so flushed ops are never reported.
  assign res_valid = nm_info_out[0] & ~flush;
  assign res_src   = nm_info_out[2:1];
  assign res_tag   = nm_info_out[INFO_W-1:3];
  assign w_consume = res_valid & res_ready;
  assign nm_wait   = res_valid & ~res_ready;
  assign nm_flush  = flush;

  // A granted slot can refill in the same cycle. Nothing is accepted while flushing.
  assign req_ready = {c_NSRC{~flush}} & (~r_slot_full | w_grant);
  assign w_accept  = req_valid & req_ready;

  assign inflight  = r_inflight;
  assign idle      = ~|r_slot_full & (r_inflight == 2'd0);

  // Arbitration uses only slot state, rr and stall, so no path runs from req_valid to req_ready.
  always_comb begin
    w_pick      = 3'b000;
    w_grant     = 3'b000;
    w_grant_any = 1'b0;
    w_grant_src = 2'd0;
    w_rr_next   = r_rr;
`ifdef F_NORM_ARB_DIV_PRIO_EN
    if (r_slot_full[2]) begin
      w_pick = 3'b110;
    end else if (r_rr == 2'd0) begin
      w_pick = f_pick({1'b0, r_slot_full[1:0]}, 2'd0, 2'd1, 2'd2);
    end else begin
      w_pick = f_pick({1'b0, r_slot_full[1:0]}, 2'd1, 2'd0, 2'd2);
    end
`else
    case (r_rr)
      2'd0:    w_pick = f_pick(r_slot_full, 2'd0, 2'd1, 2'd2);
      2'd1:    w_pick = f_pick(r_slot_full, 2'd1, 2'd2, 2'd0);
      default: w_pick = f_pick(r_slot_full, 2'd2, 2'd0, 2'd1);
    endcase
`endif
    // A stall blocks the grant. So does a flush, which squashes it.
    if (w_pick[2] && !nm_wait && !flush) begin
      w_grant_any = 1'b1;
      w_grant_src = w_pick[1:0];
      w_grant     = 3'b001 << w_pick[1:0];
`ifdef F_NORM_ARB_DIV_PRIO_EN
      // A divider grant leaves the 0/1 rotation untouched.
      w_rr_next   = (w_pick[1:0] == 2'd2) ? r_rr : {1'b0, ~w_pick[0]};
`else
      w_rr_next   = (w_pick[1:0] == 2'd2) ? 2'd0 : w_pick[1:0] + 2'd1;
`endif
    end
  end

  // Drive the f_normal operand inputs from the granted slot.
  always_comb begin
    nm_exp     = r_exp[0];
    nm_frac    = r_frac[0];
    nm_signed  = r_signed[0];
    nm_sign    = r_sign[0];
    nm_invalid = r_invalid[0];
    nm_info    = {r_tag[0], w_grant_src, w_grant_any};
    case (w_grant_src)
      2'd1: begin
        nm_exp     = r_exp[1];
        nm_frac    = r_frac[1];
        nm_signed  = r_signed[1];
        nm_sign    = r_sign[1];
        nm_invalid = r_invalid[1];
        nm_info    = {r_tag[1], w_grant_src, w_grant_any};
      end
      2'd2: begin
        nm_exp     = r_exp[2];
        nm_frac    = r_frac[2];
        nm_signed  = r_signed[2];
        nm_sign    = r_sign[2];
        nm_invalid = r_invalid[2];
        nm_info    = {r_tag[2], w_grant_src, w_grant_any};
      end
      default: ;
    endcase
  end

  // Slot occupancy: set on accept, cleared on grant. Reset and flush empty all slots.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_slot_full <= '0;
    end else begin
      r_slot_full <= w_accept | (r_slot_full & ~w_grant);
    end
  end

  // Slot payload: capture operands on accept. Payload is only read while its slot is full.
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_NSRC; i++) begin
      if (w_accept[i]) begin
        r_exp[i]     <= req_exp[i*c_EXP_W +: c_EXP_W];
        r_frac[i]    <= req_frac[i*c_FRAC_W +: c_FRAC_W];
        r_signed[i]  <= req_signed[i];
        r_sign[i]    <= req_sign[i];
        r_invalid[i] <= req_invalid[i];
        r_tag[i]     <= req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Round-robin pointer: advances past the winner and keeps its value through flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rr <= 2'd0;
    end else if (w_grant_any) begin
      r_rr <= w_rr_next;
    end
  end

  // In-flight count: +1 on grant, -1 on consume, cleared by flush.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_inflight <= 2'd0;
    end else begin
      case ({w_grant_any, w_consume})
        2'b10:   r_inflight <= r_inflight + 2'd1;
        2'b01:   r_inflight <= r_inflight - 2'd1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f_norm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_f_norm_arbiter
// Brief    : Self-checking bench for f_norm_arbiter. A behavioural 3-stage
//            f_normal model handles the info path. Per-cycle vectors are
//            compared against hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f_norm_arbiter;

  localparam int TAG_W  = 5;
  localparam int INFO_W = TAG_W + 3;

  logic                clk = 1'b0;
  logic                resetn;
  logic                flush;
  logic [2:0]          req_valid;
  logic [2:0]          req_ready;
  logic [3*13-1:0]     req_exp;
  logic [3*108-1:0]    req_frac;
  logic [2:0]          req_signed;
  logic [2:0]          req_sign;
  logic [2:0]          req_invalid;
  logic [3*TAG_W-1:0]  req_tag;
  logic                nm_wait;
  logic                nm_flush;
  logic [12:0]         nm_exp;
  logic [107:0]        nm_frac;
  logic                nm_signed;
  logic                nm_sign;
  logic                nm_invalid;
  logic [INFO_W-1:0]   nm_info;
  logic [INFO_W-1:0]   nm_info_out;
  logic                res_valid;
  logic [1:0]          res_src;
  logic [TAG_W-1:0]    res_tag;
  logic                res_ready;
  logic [1:0]          inflight;
  logic                idle;

  int n_tests = 0;
  int n_fail  = 0;

  f_norm_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_exp(req_exp), .req_frac(req_frac), .req_signed(req_signed),
    .req_sign(req_sign), .req_invalid(req_invalid), .req_tag(req_tag),
    .nm_wait(nm_wait), .nm_flush(nm_flush), .nm_exp(nm_exp), .nm_frac(nm_frac),
    .nm_signed(nm_signed), .nm_sign(nm_sign), .nm_invalid(nm_invalid),
    .nm_info(nm_info), .nm_info_out(nm_info_out),
    .res_valid(res_valid), .res_src(res_src), .res_tag(res_tag),
    .res_ready(res_ready), .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // f_normal model: three info stages. a_wait holds every stage, and flush clears the valid bits.
  logic [INFO_W-1:0] st1, st2, st3;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st1 <= '0; st2 <= '0; st3 <= '0;
    end else if (nm_flush) begin
      st1[0] <= 1'b0; st2[0] <= 1'b0; st3[0] <= 1'b0;
    end else if (!nm_wait) begin
      st1 <= nm_info; st2 <= st1; st3 <= st2;
    end
  end
  assign nm_info_out = st3;

  // Fixed per-source operand attributes
  function automatic logic [TAG_W-1:0] tag_of(input logic [1:0] s);
    case (s) 2'd0: return 5'd5; 2'd1: return 5'd10; default: return 5'd20; endcase
  endfunction
  function automatic logic [12:0] exp_of(input logic [1:0] s);
    return 13'd1023 + 13'(s);
  endfunction
  function automatic logic [107:0] frac_of(input logic [1:0] s);
    logic [107:0] one;
    one = 108'd1;
    return one << (104 - int'(s));
  endfunction

  typedef struct {
    logic       rst;
    logic [2:0] rv;
    logic       rr;
    logic       fl;
    logic [2:0] e_rdy;
    logic       e_gv;
    logic [1:0] e_gs;
    logic       e_res;
    logic [1:0] e_rs;
    logic [1:0] e_inf;
    logic       e_idle;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [2:0] rv, input logic rr,
                              input logic fl, input logic [2:0] rdy, input logic gv,
                              input logic [1:0] gs, input logic res, input logic [1:0] rs,
                              input logic [1:0] inf, input logic idl);
    vec_t v;
    v.rst = r; v.rv = rv; v.rr = rr; v.fl = fl; v.e_rdy = rdy; v.e_gv = gv;
    v.e_gs = gs; v.e_res = res; v.e_rs = rs; v.e_inf = inf; v.e_idle = idl;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic check_row(input int i, input vec_t v);
    string p;
    p = $sformatf("row%0d", i);
    check({p, " req_ready"}, 128'(req_ready), 128'(v.e_rdy));
    check({p, " grant_valid"}, 128'(nm_info[0]), 128'(v.e_gv));
    check({p, " nm_flush"}, 128'(nm_flush), 128'(v.fl));
    check({p, " res_valid"}, 128'(res_valid), 128'(v.e_res));
    check({p, " nm_wait"}, 128'(nm_wait), 128'(v.e_res & ~v.rr));
    check({p, " inflight"}, 128'(inflight), 128'(v.e_inf));
    check({p, " idle"}, 128'(idle), 128'(v.e_idle));
    if (v.e_gv) begin
      check({p, " grant_src"}, 128'(nm_info[2:1]), 128'(v.e_gs));
      check({p, " grant_tag"}, 128'(nm_info[INFO_W-1:3]), 128'(tag_of(v.e_gs)));
      check({p, " nm_exp"}, 128'(nm_exp), 128'(exp_of(v.e_gs)));
      check({p, " nm_frac"}, 128'(nm_frac), 128'(frac_of(v.e_gs)));
      check({p, " nm_flags"}, 128'({nm_signed, nm_sign, nm_invalid}),
            128'({v.e_gs == 2'd2, v.e_gs == 2'd1, v.e_gs != 2'd0}));
    end
    if (v.e_res) begin
      check({p, " res_src"}, 128'(res_src), 128'(v.e_rs));
      check({p, " res_tag"}, 128'(res_tag), 128'(tag_of(v.e_rs)));
    end
  endtask

  initial begin
    for (int s = 0; s < 3; s++) begin
      req_exp[s*13 +: 13]        = exp_of(2'(s));
      req_frac[s*108 +: 108]     = frac_of(2'(s));
      req_tag[s*TAG_W +: TAG_W]  = tag_of(2'(s));
      req_signed[s]              = (s == 2);
      req_sign[s]                = (s == 1);
      req_invalid[s]             = (s != 0);
    end
    resetn = 1'b0; flush = 1'b0; req_valid = 3'b000; res_ready = 1'b1;

    // Reset, then a single adder op: grant at t1, result at t4
    tbl.push_back(mk(1, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b001, 1, 0, 3'b111, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 0, 0, 0, 1));
    // Re-reset so rr starts at 0
    tbl.push_back(mk(1, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
`ifndef F_NORM_ARB_DIV_PRIO_EN
    // All sources valid: rotation 0,1,2 and one result per cycle
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b111, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b001, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b010, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b100, 1, 2, 0, 0, 2, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b001, 1, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b010, 1, 1, 1, 1, 3, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b100, 1, 2, 1, 2, 3, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b001, 1, 0, 1, 0, 3, 0));
    // Back-pressure: stall, then resume with order preserved
    tbl.push_back(mk(0, 3'b111, 0, 0, 3'b000, 0, 0, 1, 1, 3, 0));
    tbl.push_back(mk(0, 3'b111, 0, 0, 3'b000, 0, 0, 1, 1, 3, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b010, 1, 1, 1, 1, 3, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b110, 1, 2, 1, 2, 3, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 1, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 3'b011, 1, 0, 3'b111, 0, 0, 1, 1, 3, 0));
    // Flush with 2 in flight, 2 slots full and a new request present
    tbl.push_back(mk(0, 3'b100, 1, 1, 3'b000, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 0, 0, 0, 1));
    // rr still points at src 1 after the squashed grant
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b111, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b010, 1, 1, 0, 0, 0, 0));
`else
    // Divider priority: src 2 wins whenever its slot is full
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b111, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b100, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b100, 1, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b100, 1, 2, 0, 0, 2, 0));
    tbl.push_back(mk(0, 3'b111, 1, 0, 3'b100, 1, 2, 1, 2, 3, 0));
    tbl.push_back(mk(0, 3'b011, 1, 0, 3'b100, 1, 2, 1, 2, 3, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b101, 1, 0, 1, 2, 3, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 1, 1, 1, 2, 3, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 1, 2, 3, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 1, 0, 2, 0));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b111, 0, 0, 1, 1, 1, 0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      resetn    = ~tbl[i].rst;
      req_valid = tbl[i].rv;
      res_ready = tbl[i].rr;
      flush     = tbl[i].fl;
      #1;
      if (!tbl[i].rst) check_row(i, tbl[i]);
    end

    // Reset while slots are full and ops are in flight discards everything
    @(negedge clk);
    resetn = 1'b0; req_valid = 3'b000; flush = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("midreset req_ready", 128'(req_ready), 128'(3'b111));
    check("midreset idle", 128'(idle), 128'(1'b1));
    check("midreset inflight", 128'(inflight), 128'(2'd0));
    check("midreset grant_valid", 128'(nm_info[0]), 128'(1'b0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("midreset res_valid c%0d", k), 128'(res_valid), 128'(1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
